operand_issue: RTL
==================

# operand_issue

Upstream operand-issue stage for the CPU's 8-bit dual-operand datapath unit. It accepts (A, B) operand pairs from the decode/fetch side over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents the oldest pair on `Ain`/`Bin`, which feed the combinational pair unit directly downstream. The downstream consumer pops one pair per cycle by asserting `issue_ready`.

## Interface
- `DATA_W`, 8: operand width for A and B.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all buffered pairs.
- `in_valid`  in  1  upstream has a pair on `in_a`/`in_b`.
- `in_ready`  out  1  stage can accept a pair this cycle.
- `in_a`  in  DATA_W  operand A.
- `in_b`  in  DATA_W  operand B.
- `issue_valid`  out  1  `Ain`/`Bin` hold a valid pair.
- `issue_ready`  in  1  downstream consumes the pair this cycle.
- `Ain`  out  DATA_W  head operand A; 0 when `issue_valid`=0.
- `Bin`  out  DATA_W  head operand B; 0 when `issue_valid`=0.
- `level`  out  $clog2(DEPTH)+1  number of buffered pairs.
- `issue_cnt`  out  16  pairs issued (present only with STATS_EN, see Configuration).

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `issue_valid && issue_ready`.
- State machine has three states:
  - EMPTY (`level`=0).
  - PARTIAL (0<`level`<DEPTH).
  - FULL (`level`=DEPTH).
- Transitions:
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop at `level`=DEPTH-1.
  - PARTIAL→EMPTY on pop without push at `level`=1.
  - FULL→PARTIAL on pop.
  - Any state→EMPTY on `flush`.
- `in_ready` = (state != FULL). While FULL, a push is refused even if a pop occurs in the same cycle; no bypass.
- `issue_valid` = (state != EMPTY).
- Simultaneous push and pop in PARTIAL: `level` is unchanged and state is unchanged.
- `issue_ready` while EMPTY is ignored.
- Pointer arithmetic:
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no extra handling.
  - `level` is tracked separately and is never derived from pointer difference.
- `flush` has priority over push and pop in the same cycle:
  - pointers are set to 0, `level` to 0, state to EMPTY;
  - the pair offered on `in_a`/`in_b` that cycle is dropped.
- Operands are stored unmodified; the stage does no arithmetic on them.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state EMPTY, pointers 0, `level` 0;
  - `in_ready`=1, `issue_valid`=0, `Ain`=`Bin`=0, `issue_cnt`=0.
- Storage contents are not reset.
- Push-to-issue latency is 1 cycle: a pair pushed at edge N into EMPTY appears on `Ain`/`Bin` with `issue_valid`=1 after edge N.
- Pop takes effect at the edge. The next pair, if any, is presented in the following cycle with no bubble, so sustained throughput is 1 pair/cycle.
- `Ain`/`Bin` change only at clock edges or on reset; they are read combinationally from registered storage through the read-pointer mux and the zero gate.
- `rst` asserted mid-stream discards all pairs. The first push after `rst` deasserts is accepted on the first edge.
- `flush` results are visible on the cycle after the asserting edge.

## Configuration
- `OPERAND_ISSUE_STATS_EN` defined:
  - `issue_cnt` port exists.
  - It increments by 1 on every pop and wraps 0xFFFF→0.
  - It is cleared only by `rst`; `flush` does not clear it.
- `OPERAND_ISSUE_STATS_EN` undefined: the `issue_cnt` port and its counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `operand_issue_pkg` holds:
  - state enum (EMPTY, PARTIAL, FULL);
  - default `DATA_W`/`DEPTH` constants;
  - `issue_cnt` width constant (16).
- Sub-module `operand_fifo_mem`: DEPTH×(2·DATA_W) storage with one write port and a combinational read port indexed by pointer.
- The top level holds the pointers, `level`, the state machine, the handshakes, the zero gate and the optional stats counter.

## Test plan
- Reset then idle → `in_ready`=1, `issue_valid`=0, `Ain`=`Bin`=0, `level`=0.
- Push (67,111) with `issue_ready`=0 → after 1 edge `Ain`=67, `Bin`=111, `issue_valid`=1; pair held stable over 5 cycles.
- Fill-to-full, DEPTH=4:
  - Push (67,111), (147,25), (89,28), (40,154) with `issue_ready`=0 → `level`=4, `in_ready`=0.
  - Push (245,128) while full → refused.
  - Pop 4 times → output order 67/111, 147/25, 89/28, 40/154, then EMPTY with `Ain`=`Bin`=0.
- Streaming with pointer wrap: push and pop every cycle for 9 pairs (67,111)…(152,223) → each pair issued exactly 1 cycle after its push, `level` stays 1, in-order output across pointer wrap.
- Flush priority: with `level`=3, assert `flush` together with a push of (154,120) and a pop → next cycle `level`=0, `issue_valid`=0, (154,120) never issued.
- Stats with `OPERAND_ISSUE_STATS_EN` defined:
  - after 9 pops `issue_cnt`=9;
  - after `flush` `issue_cnt` is still 9;
  - `rst` pulse mid-cycle → `issue_cnt`=0 immediately.

Source files
------------

// File: rtl/operand_issue_pkg.sv
// Shared types and defaults for the operand issue stage.
package operand_issue_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int ISSUE_CNT_W = 16;

endpackage

// File: rtl/operand_fifo_mem.sv
// Operand pair storage: one synchronous write port, one combinational read port.
// Write visible on the read port the cycle after the write edge; no flow control of its own.
// Contents are deliberately not reset.
module operand_fifo_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdat,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdat
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/operand_issue.sv
// Buffers (A,B) operand pairs in a DEPTH-entry FIFO and presents the head on Ain/Bin.
// Push-to-issue latency 1 cycle, 1 pair/cycle sustained; in_ready drops only when FULL (no bypass).
// Optional issue counter enabled by OPERAND_ISSUE_STATS_EN.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [DATA_W-1:0]        Ain,
  output logic [DATA_W-1:0]        Bin,
  output logic [$clog2(DEPTH):0]   level
`ifdef OPERAND_ISSUE_STATS_EN
  ,
  output logic [ISSUE_CNT_W-1:0]   issue_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  state_t            state, state_nxt;
  logic [LW-1:0]     level_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [2*DATA_W-1:0] rd_dat;
  logic              push, pop;

  assign in_ready    = (state != FULL);
  assign issue_valid = (state != EMPTY);
  assign push        = in_valid && in_ready;
  assign pop         = issue_valid && issue_ready;

  operand_fifo_mem #(.W(2*DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdat  ({in_a, in_b}),
    .raddr (rd_ptr),
    .rdat  (rd_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (flush) begin
      state_nxt = EMPTY;
      level_nxt = '0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_nxt = PARTIAL;
          level_nxt = LW'(1);
        end
        PARTIAL: begin
          if (push && !pop) begin
            level_nxt = level + LW'(1);
            if (level == LW'(DEPTH - 1)) state_nxt = FULL;
          end else if (pop && !push) begin
            level_nxt = level - LW'(1);
            if (level == LW'(1)) state_nxt = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_nxt = PARTIAL;
          level_nxt = level - LW'(1);
        end
        default: begin
          state_nxt = EMPTY;
          level_nxt = '0;
        end
      endcase
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level is tracked independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign Ain = issue_valid ? rd_dat[2*DATA_W-1:DATA_W] : '0;
  assign Bin = issue_valid ? rd_dat[DATA_W-1:0]        : '0;

`ifdef OPERAND_ISSUE_STATS_EN
  // A pop coinciding with flush is overridden by the flush, so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               issue_cnt <= '0;
    else if (pop && !flush) issue_cnt <= issue_cnt + ISSUE_CNT_W'(1);
  end
`endif

endmodule
